// File: rtl/snake_score_counter.sv
// snake_score_counter
//
// Counts target-collected events while the master state machine is in PLAY,
// raises SCORE_REACHED once the two-digit BCD score equals WIN_SCORE, and
// multiplexes the score onto a four-digit common-anode 7-segment display.
//
// Ports:
//   CLK            in   system clock
//   RESET          in   synchronous, active-high reset
//   MSM_STATE      in   master state: 00 IDLE, 01 PLAY, 10 WIN, 11 treated as IDLE
//   TARGET_REACHED in   level, high while the snake head sits on the target
//   SCORE_REACHED  out  registered, high once score equals WIN_SCORE
//   SEG_SELECT_OUT out  digit anodes, active-low one-hot, bit 0 = rightmost digit
//   HEX_OUT        out  segments, active-low, bit 7 = DP (always off), bits 6:0 = g..a
//
// Parameters:
//   WIN_SCORE      score that ends the game (1..99)
//   REFRESH_DIV    CLK cycles each digit stays selected

module snake_score_counter #(
    parameter int unsigned WIN_SCORE   = 10,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_STATE,
    input  logic       TARGET_REACHED,
    output logic       SCORE_REACHED,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] HEX_OUT
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Win threshold split into BCD digits so the compare stays digit-wise.
    localparam logic [3:0] WIN_TENS  = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_UNITS = 4'(WIN_SCORE % 10);

    // Any code outside 0..9 encodes as a blank digit.
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    localparam logic [7:0] HEX_RESET  = 8'hC0;
    localparam logic [3:0] SEL_RESET  = 4'b1110;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StWin  = 2'b10,
        StRsvd = 2'b11
    } msm_state_e;

    // ------------------------------------------------------------------------
    // Segment encoder (active-low, DP off)
    // ------------------------------------------------------------------------
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic             prev_target_q;
    logic [3:0]       score_units_q, score_units_d;
    logic [3:0]       score_tens_q,  score_tens_d;
    logic             score_reached_q, score_reached_d;
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       digit_idx_q,   digit_idx_d;
    logic [3:0]       seg_select_q,  seg_select_d;
    logic [7:0]       hex_q,         hex_d;

    msm_state_e msm_state;
    logic       inc;

    assign msm_state = msm_state_e'(MSM_STATE);

    // A held-high TARGET_REACHED only counts on its first sampled cycle.
    assign inc = TARGET_REACHED & ~prev_target_q;

    // ------------------------------------------------------------------------
    // Score next-state
    // ------------------------------------------------------------------------
    always_comb begin
        logic [3:0] units_nx;
        logic [3:0] tens_nx;

        units_nx        = score_units_q;
        tens_nx         = score_tens_q;
        score_reached_d = score_reached_q;

        case (msm_state)
            StPlay: begin
                // Once the win score is reached the score is frozen.
                if (inc && !score_reached_q) begin
                    if (score_units_q == 4'd9) begin
                        units_nx = 4'd0;
                        tens_nx  = score_tens_q + 4'd1;
                    end else begin
                        units_nx = score_units_q + 4'd1;
                    end
                    // Registered alongside the score so both change on one edge.
                    score_reached_d = (units_nx == WIN_UNITS) && (tens_nx == WIN_TENS);
                end
            end
            StWin: begin
                // Hold score and win flag; increments are ignored.
            end
            default: begin
                // IDLE and the unused encoding both clear; a coincident
                // increment is dropped.
                units_nx        = 4'd0;
                tens_nx         = 4'd0;
                score_reached_d = 1'b0;
            end
        endcase

        score_units_d = units_nx;
        score_tens_d  = tens_nx;
    end

    // ------------------------------------------------------------------------
    // Display refresh: one digit per REFRESH_DIV cycles
    // ------------------------------------------------------------------------
    always_comb begin
        refresh_cnt_d = refresh_cnt_q;
        digit_idx_d   = digit_idx_q;
        if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx_q + 2'd1;
        end else begin
            refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Digit mux and encode, registered one cycle behind digit_idx/score
    // ------------------------------------------------------------------------
    always_comb begin
        logic [3:0] digit_sel;

        digit_sel = DIGIT_BLANK;
        case (digit_idx_q)
            2'd0:    digit_sel = score_units_q;
            // Leading zero on the tens digit is suppressed.
            2'd1:    digit_sel = (score_tens_q == 4'd0) ? DIGIT_BLANK : score_tens_q;
            default: digit_sel = DIGIT_BLANK;
        endcase

        seg_select_d = ~(4'b0001 << digit_idx_q);
        hex_d        = seg_encode(digit_sel);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_target_q   <= 1'b0;
            score_units_q   <= 4'd0;
            score_tens_q    <= 4'd0;
            score_reached_q <= 1'b0;
            refresh_cnt_q   <= '0;
            digit_idx_q     <= 2'd0;
            seg_select_q    <= SEL_RESET;
            hex_q           <= HEX_RESET;
        end else begin
            prev_target_q   <= TARGET_REACHED;
            score_units_q   <= score_units_d;
            score_tens_q    <= score_tens_d;
            score_reached_q <= score_reached_d;
            refresh_cnt_q   <= refresh_cnt_d;
            digit_idx_q     <= digit_idx_d;
            seg_select_q    <= seg_select_d;
            hex_q           <= hex_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign SCORE_REACHED  = score_reached_q;
    assign SEG_SELECT_OUT = seg_select_q;
    assign HEX_OUT        = hex_q;

endmodule

// File: tb/tb_snake_score_counter.sv
// Bench for snake_score_counter: directed phases followed by random stimulus.
// A stimulus task updates an integer-score reference model and queues the
// expected post-edge outputs; a monitor on the falling edge pops and compares.

module tb_snake_score_counter;

    localparam int unsigned WIN = 10;
    localparam int unsigned DIV = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] MSM_STATE = 2'b00;
    logic       TARGET_REACHED = 1'b0;
    logic       SCORE_REACHED;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] HEX_OUT;

    snake_score_counter #(
        .WIN_SCORE   (WIN),
        .REFRESH_DIV (DIV)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MSM_STATE      (MSM_STATE),
        .TARGET_REACHED (TARGET_REACHED),
        .SCORE_REACHED  (SCORE_REACHED),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .HEX_OUT        (HEX_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       reached;
        logic [3:0] seg;
        logic [7:0] hex;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: score as a plain integer, display position derived
    // from the number of clock edges since the last reset.
    int m_score   = 0;
    bit m_reached = 1'b0;
    bit m_prev    = 1'b0;
    int m_t       = 0;

    function automatic logic [7:0] enc(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (d < 0 || d > 9) return 8'hFF;
        return tbl[d];
    endfunction

    // Drive one cycle of inputs, predict the state after the coming edge.
    task automatic step(input bit rst, input logic [1:0] st, input bit tgt);
        exp_t e;
        int   idx;
        int   dval;
        RESET          = rst;
        MSM_STATE      = st;
        TARGET_REACHED = tgt;
        if (rst) begin
            m_score   = 0;
            m_reached = 1'b0;
            m_prev    = 1'b0;
            m_t       = 0;
            e.seg     = 4'b1110;
            e.hex     = 8'hC0;
        end else begin
            // Display shows the position/score held before this edge.
            idx        = (m_t / DIV) % 4;
            e.seg      = 4'b1111;
            e.seg[idx] = 1'b0;
            if (idx == 0)      dval = m_score % 10;
            else if (idx == 1) dval = (m_score / 10 == 0) ? -1 : m_score / 10;
            else               dval = -1;
            e.hex = enc(dval);
            if (st == 2'b01) begin
                if (tgt && !m_prev && m_score < WIN) m_score++;
                m_reached = (m_score == WIN);
            end else if (st != 2'b10) begin
                m_score   = 0;
                m_reached = 1'b0;
            end
            m_prev = tgt;
            m_t++;
        end
        e.reached = m_reached;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [1:0] st, input int gap);
        step(1'b0, st, 1'b1);
        for (int i = 0; i < gap; i++) step(1'b0, st, 1'b0);
    endtask

    // Monitor: one expected entry per edge, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (SCORE_REACHED !== e.reached) begin
                    n_fail++;
                    $display("FAIL score_reached t=%0t: got %b expected %b",
                             $time, SCORE_REACHED, e.reached);
                end
                n_tests++;
                if (SEG_SELECT_OUT !== e.seg) begin
                    n_fail++;
                    $display("FAIL seg_select t=%0t: got %b expected %b",
                             $time, SEG_SELECT_OUT, e.seg);
                end
                n_tests++;
                if (HEX_OUT !== e.hex) begin
                    n_fail++;
                    $display("FAIL hex_out t=%0t: got %h expected %h",
                             $time, HEX_OUT, e.hex);
                end
            end
        end
    end

    initial begin
        logic [1:0] st;
        bit         tgt;
        int         run;

        // Reset held three cycles, then idle to watch the anode rotation.
        repeat (3) step(1'b1, 2'b00, 1'b0);
        repeat (20) step(1'b0, 2'b00, 1'b0);

        // Long pulse counts once.
        repeat (20) step(1'b0, 2'b01, 1'b1);
        repeat (16) step(1'b0, 2'b01, 1'b0);

        // Climb to the win score and beyond (saturation).
        repeat (12) pulse(2'b01, 2);
        repeat (16) step(1'b0, 2'b01, 1'b0);

        // WIN holds, pulses ignored; IDLE clears and ignores pulses.
        repeat (3) pulse(2'b10, 3);
        repeat (8) step(1'b0, 2'b10, 1'b0);
        repeat (3) pulse(2'b00, 2);
        repeat (3) pulse(2'b11, 1);

        // Collision: rising target on the same edge as PLAY -> IDLE.
        repeat (4) pulse(2'b01, 1);
        step(1'b0, 2'b00, 1'b1);
        repeat (6) step(1'b0, 2'b00, 1'b0);

        // Units wrap 9 -> 0 with carry.
        repeat (9) pulse(2'b01, 1);
        repeat (16) step(1'b0, 2'b01, 1'b0);
        pulse(2'b01, 16);

        // Mid-operation reset with a coincident rising target.
        step(1'b0, 2'b00, 1'b0);
        repeat (7) pulse(2'b01, 1);
        step(1'b1, 2'b01, 1'b1);
        repeat (20) step(1'b0, 2'b01, 1'b1);
        repeat (4) step(1'b0, 2'b01, 1'b0);

        // Random phase: state held for random runs, target toggles randomly.
        st  = 2'b01;
        tgt = 1'b0;
        run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    st = 2'b00;
                    2:       st = 2'b11;
                    3, 4:    st = 2'b10;
                    default: st = 2'b01;
                endcase
                run = $urandom_range(5, 120);
            end
            run--;
            if ($urandom_range(0, 3) == 0) tgt = ~tgt;
            step(($urandom_range(0, 299) == 0), st, tgt);
        end

        // Drain outstanding expectations within a bounded window.
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d entries pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_score_counter.md
Name: snake_score_counter

Overview:
- Consumer of the master state machine's 2-bit state, and producer of its win-condition input.
- Counts target-collected events from the snake datapath during PLAY and asserts SCORE_REACHED when the score hits WIN_SCORE.
- Multiplexes the two-digit decimal score onto the board's four-digit common-anode 7-segment display.
- Sits beside the master state machine in the top level. SCORE_REACHED drives the master's PLAY-to-WIN transition.

Parameters:
- WIN_SCORE, 10: score that asserts SCORE_REACHED. Legal range 1..99.
- REFRESH_DIV, 100000: CLK cycles per displayed digit (1 kHz digit rate at 100 MHz).

Ports:
- CLK  input  1  system clock (100 MHz).
- RESET  input  1  synchronous, active-high reset.
- MSM_STATE  input  2  master state: 2'b00 IDLE, 2'b01 PLAY, 2'b10 WIN. 2'b11 is treated as IDLE.
- TARGET_REACHED  input  1  level from snake control, high while the head is on the target. Synchronous to CLK.
- SCORE_REACHED  output  1  high once score equals WIN_SCORE.
- SEG_SELECT_OUT  output  4  digit anodes, active-low one-hot. Bit 0 is the rightmost digit.
- HEX_OUT  output  8  segments, active-low. Bit 7 = DP (always 1), bits 6:0 = g..a.

Behaviour:
- Reset (RESET=1 at a rising edge) sets:
  - score_units = 0, score_tens = 0, SCORE_REACHED = 0, prev_target = 0;
  - refresh_cnt = 0, digit_idx = 0;
  - SEG_SELECT_OUT = 4'b1110, HEX_OUT = 8'hC0.
  - Reset mid-operation behaves identically. RESET overrides all other inputs.
- Edge detect:
  - prev_target <= TARGET_REACHED every cycle.
  - inc = TARGET_REACHED & ~prev_target.
  - A held-high TARGET_REACHED counts exactly once.
- Score, two BCD digits, updated on each rising edge:
  - MSM_STATE IDLE or 2'b11: score cleared to 00, SCORE_REACHED cleared.
  - PLAY with inc=1 and SCORE_REACHED=0: score += 1. Units wrap 9 -> 0 with a carry into tens.
  - PLAY with SCORE_REACHED=1: score frozen (saturates at WIN_SCORE).
  - WIN: score and SCORE_REACHED hold.
- Latency:
  - Score is visible one cycle after TARGET_REACHED is first sampled high.
  - SCORE_REACHED is registered and asserts on the same edge that score becomes WIN_SCORE.
  - It stays high through WIN until MSM_STATE returns to IDLE or RESET.
- Simultaneous events:
  - inc coincident with an IDLE state: the clear wins, the increment is dropped.
  - inc coincident with WIN: ignored.
  - Decisions use the sampled MSM_STATE of that edge.
- Display refresh:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit_idx advances 0 -> 1 -> 2 -> 3 -> 0.
- Digit mapping:
  - idx0: units.
  - idx1: tens, blanked (8'hFF) when tens = 0.
  - idx2 and idx3: blank 8'hFF.
- Output registers:
  - SEG_SELECT_OUT = ~(1 << digit_idx).
  - HEX_OUT = encoding of the selected digit.
  - Both update on the edge after digit_idx or score changes (one-cycle pipeline). This is not glitch-critical.
- Encoding (DP off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, blank FF.
- Score never exceeds WIN_SCORE. No 99 -> 00 wrap occurs when WIN_SCORE ≤ 99.

Test Plan:
Benches use REFRESH_DIV=4 and WIN_SCORE=10 unless stated.
- Reset: hold RESET 3 cycles -> SCORE_REACHED=0, SEG_SELECT_OUT=4'b1110, HEX_OUT=8'hC0. After release, SEG_SELECT_OUT steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step every 4 cycles.
- Single count with long pulse: MSM_STATE=01, TARGET_REACHED high for 20 cycles -> score=01 exactly once, updated 1 cycle after the pulse starts. idx0 shows F9, idx1 shows FF.
- Win: 10 separated pulses in PLAY -> SCORE_REACHED rises on the edge of the 10th count. idx1 shows F9, idx0 shows C0. An 11th pulse leaves score at 10.
- State gating: 3 pulses in IDLE -> score stays 00. Enter WIN with score 10, apply pulses -> score 10, SCORE_REACHED=1. MSM_STATE -> 00 -> score 00 and SCORE_REACHED=0 next edge.
- Collision: a rising TARGET_REACHED on the same edge as MSM_STATE changes 01 -> 00 -> score 00, no increment. Score 09 with a pulse -> units wrap to 0, tens = 1.
- Mid-operation reset: score 07, assert RESET concurrent with a TARGET_REACHED rising edge -> score 00, outputs at reset values next cycle.
